// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the branch unit and its jump-target ROM.
//   - Branch-class opcode, condition codes and the reserved link indices.
//   - Branch unit run/halt states.
//   - Default PC and instruction widths.
//   - lut_image(): built-in jump-target image used by jump_lut.
package cpu_pkg;

    localparam int unsigned PW_DEF = 8;
    localparam int unsigned IW_DEF = 9;

    localparam logic [2:0] OP_BRANCH = 3'b111;
    localparam logic [3:0] IDX_HALT  = 4'd14;
    localparam logic [3:0] IDX_RET   = 4'd15;

    typedef enum logic [1:0] {C_BR, C_BZ, C_BNZ, C_LINK} cond_t;
    typedef enum logic [1:0] {IDLE, RUN, HALT} bu_state_t;

    // Jump-target image: entry i holds 13*i + 1 (entry 3 -> 40).
    function automatic int unsigned lut_image(input int unsigned i);
        return 13 * i + 1;
    endfunction

endpackage

// File: rtl/branch_unit_jump_lut.sv
// jump_lut: LUT_DEPTH x PW jump-target ROM with asynchronous read.
// Ports:
//   idx  in   $clog2(LUT_DEPTH)  entry select (Instruction[3:0])
//   data out  PW                 jump target stored at idx
// LUT_FILE names the ROM image; an empty name yields an all-zero ROM,
// any other name selects the built-in image from cpu_pkg::lut_image.
module jump_lut
    import cpu_pkg::*;
#(
    parameter int unsigned PW        = PW_DEF,
    parameter int unsigned LUT_DEPTH = 16,
    parameter              LUT_FILE  = "jump_lut.hex"
) (
    input  logic [$clog2(LUT_DEPTH)-1:0] idx,
    output logic [PW-1:0]                data
);

    logic [PW-1:0] rom [LUT_DEPTH];

    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
        if (LUT_FILE == "") begin : g_blank
            assign rom[i] = '0;
        end else begin : g_image
            assign rom[i] = PW'(lut_image(i));
        end
    end

    assign data = rom[idx];

endmodule

// File: rtl/branch_unit.sv
// branch_unit: decodes branch-class instructions and drives the PC's
// Jen/Jump inputs combinationally; holds the Z flag, link storage and the
// IDLE/RUN/HALT state machine.
// Ports:
//   Clk, Reset   clock, synchronous active-high reset
//   start        pulse: (re)start a program, enters RUN
//   Instruction  current instruction (IW bits)
//   PC           address of current instruction (PW bits)
//   zero_in      ALU zero result, captured into Z when flag_we in RUN
//   flag_we      Z write enable
//   Jen, Jump    jump enable / target to the PC (combinational)
//   done         registered, high while halted
//   link_err     registered, sticky: RET on empty link or dropped push
// Optional macro LINK_STACK_EN: link becomes a STACK_DEPTH-entry LIFO;
// otherwise a single link register (STACK_DEPTH unused).
module branch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PW          = PW_DEF,
    parameter int unsigned IW          = IW_DEF,
    parameter int unsigned LUT_DEPTH   = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter              LUT_FILE    = "jump_lut.hex"
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [IW-1:0] Instruction,
    input  logic [PW-1:0] PC,
    input  logic          zero_in,
    input  logic          flag_we,
    output logic          Jen,
    output logic [PW-1:0] Jump,
    output logic          done,
    output logic          link_err
);

    bu_state_t     state, state_next;
    logic          z;
    logic [2:0]    op;
    cond_t         cond;
    logic [3:0]    idx;
    logic [PW-1:0] lut_data;
    logic [PW-1:0] link_top;
    logic          link_valid;
    logic          push, pop, ret_miss, push_drop;

    assign op   = Instruction[IW-1 -: 3];
    assign cond = cond_t'(Instruction[5:4]);
    assign idx  = Instruction[3:0];

    jump_lut #(
        .PW       (PW),
        .LUT_DEPTH(LUT_DEPTH),
        .LUT_FILE (LUT_FILE)
    ) u_lut (
        .idx (idx),
        .data(lut_data)
    );

    always_comb begin
        state_next = state;
        Jen        = 1'b0;
        Jump       = '0;
        push       = 1'b0;
        pop        = 1'b0;
        ret_miss   = 1'b0;
        unique case (state)
            IDLE: ;
            RUN: begin
                if (op == OP_BRANCH) begin
                    unique case (cond)
                        C_BR: begin
                            Jen  = 1'b1;
                            Jump = lut_data;
                        end
                        C_BZ: if (z) begin
                            Jen  = 1'b1;
                            Jump = lut_data;
                        end
                        C_BNZ: if (!z) begin
                            Jen  = 1'b1;
                            Jump = lut_data;
                        end
                        C_LINK: begin
                            if (idx == IDX_HALT) begin
                                // Hold the PC on the HALT instruction itself.
                                Jen        = 1'b1;
                                Jump       = PC;
                                state_next = HALT;
                            end else if (idx == IDX_RET) begin
                                if (link_valid) begin
                                    Jen  = 1'b1;
                                    Jump = link_top;
                                    pop  = 1'b1;
                                end else begin
                                    ret_miss = 1'b1;
                                end
                            end else begin
                                Jen  = 1'b1;
                                Jump = lut_data;
                                push = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            HALT: begin
                Jen  = 1'b1;
                Jump = PC;
            end
            default: state_next = IDLE;
        endcase
        // Outputs above follow the current state; start only redirects the next state.
        if (start) state_next = RUN;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            z        <= 1'b0;
            done     <= 1'b0;
            link_err <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == HALT);
            if (start) begin
                z        <= 1'b0;
                link_err <= 1'b0;
            end else begin
                if (state == RUN && flag_we) z <= zero_in;
                if (ret_miss || push_drop) link_err <= 1'b1;
            end
        end
    end

`ifdef LINK_STACK_EN
    localparam int unsigned SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

    logic [PW-1:0] stack [STACK_DEPTH];
    logic [CW-1:0] count;

    assign link_valid = (count != '0);
    assign push_drop  = push && (count == CW'(STACK_DEPTH));
    assign link_top   = stack[SW'(count - 1'b1)];

    always_ff @(posedge Clk) begin
        if (Reset || start) begin
            count <= '0;
        end else if (push && !push_drop) begin
            stack[SW'(count)] <= PC + PW'(1);
            count             <= count + 1'b1;
        end else if (pop) begin
            count <= count - 1'b1;
        end
    end
`else
    logic [PW-1:0] link_reg;
    logic          link_vld;

    assign link_valid = link_vld;
    assign link_top   = link_reg;
    assign push_drop  = 1'b0;

    always_ff @(posedge Clk) begin
        if (Reset || start) begin
            link_reg <= '0;
            link_vld <= 1'b0;
        end else if (push) begin
            link_reg <= PC + PW'(1);
            link_vld <= 1'b1;
        end else if (pop) begin
            link_vld <= 1'b0;
        end
    end

    // Single link register: depth setting has no effect in this build.
    if (STACK_DEPTH == 0) begin : g_stack_depth_unused
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed vectors with literal expectations plus a
// cycle-by-cycle reference model of the branch unit.
module tb_branch_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] Instruction = '0;
    logic [7:0] PC = '0;
    logic       zero_in = 1'b0;
    logic       flag_we = 1'b0;
    logic       Jen;
    logic [7:0] Jump;
    logic       done;
    logic       link_err;

    always #5 Clk = ~Clk;

    branch_unit #(
        .PW         (8),
        .IW         (9),
        .LUT_DEPTH  (16),
        .STACK_DEPTH(4),
        .LUT_FILE   ("jump_lut.hex")
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .Instruction(Instruction),
        .PC         (PC),
        .zero_in    (zero_in),
        .flag_we    (flag_we),
        .Jen        (Jen),
        .Jump       (Jump),
        .done       (done),
        .link_err   (link_err)
    );

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
`ifdef LINK_STACK_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    int m_state = 0;   // 0 idle, 1 running, 2 halted
    bit m_z = 0, m_err = 0, m_done = 0;
    int m_link[$];

    function automatic int lut_val(input int i);
        return (13 * i + 1) % 256;
    endfunction

    always @(negedge Clk) begin
        int op, cond, ix, ejen, ejump, nstate;
        bit do_push, do_pop, do_miss;
        if (armed) begin
            op = int'(Instruction[8:6]);
            cond = int'(Instruction[5:4]);
            ix = int'(Instruction[3:0]);
            ejen = 0; ejump = 0; nstate = m_state;
            do_push = 0; do_pop = 0; do_miss = 0;
            if (m_state == 2) begin
                ejen = 1; ejump = int'(PC);
            end else if (m_state == 1 && op == 7) begin
                case (cond)
                    0: begin ejen = 1; ejump = lut_val(ix); end
                    1: if (m_z)  begin ejen = 1; ejump = lut_val(ix); end
                    2: if (!m_z) begin ejen = 1; ejump = lut_val(ix); end
                    default: begin
                        if (ix == 14) begin
                            ejen = 1; ejump = int'(PC); nstate = 2;
                        end else if (ix == 15) begin
                            if (m_link.size() > 0) begin
                                ejen = 1; ejump = m_link[$]; do_pop = 1;
                            end else do_miss = 1;
                        end else begin
                            ejen = 1; ejump = lut_val(ix); do_push = 1;
                        end
                    end
                endcase
            end
            check("model_jen", Jen, ejen);
            check("model_jump", Jump, ejump);
            check("model_done", done, m_done);
            check("model_link_err", link_err, m_err);
            if (Reset) begin
                m_state = 0; m_z = 0; m_err = 0; m_done = 0; m_link.delete();
            end else if (start) begin
                m_state = 1; m_z = 0; m_err = 0; m_done = 0; m_link.delete();
            end else begin
                if (m_state == 1) begin
                    if (flag_we) m_z = zero_in;
                    if (do_push) begin
                        if (CAP == 1) begin
                            m_link.delete();
                            m_link.push_back((int'(PC) + 1) % 256);
                        end else if (m_link.size() < CAP)
                            m_link.push_back((int'(PC) + 1) % 256);
                        else m_err = 1;
                    end
                    if (do_pop) void'(m_link.pop_back());
                    if (do_miss) m_err = 1;
                end
                m_state = nstate;
                m_done = (nstate == 2);
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct packed {
        bit       rst;
        bit       st;
        bit [8:0] instr;
        bit [7:0] pc;
        bit       fwe;
        bit       zin;
        bit       chk;
        bit       ejen;
        bit [7:0] ejump;
        bit       edone;
        bit       eerr;
    } vec_t;

    task automatic apply(input vec_t v, input string tag, input int n);
        @(posedge Clk);
        #1;
        Reset = v.rst; start = v.st; Instruction = v.instr; PC = v.pc;
        flag_we = v.fwe; zero_in = v.zin;
        @(negedge Clk);
        if (v.chk) begin
            check($sformatf("%s%0d_jen", tag, n), Jen, v.ejen);
            check($sformatf("%s%0d_jump", tag, n), Jump, v.ejump);
            check($sformatf("%s%0d_done", tag, n), done, v.edone);
            check($sformatf("%s%0d_link_err", tag, n), link_err, v.eerr);
        end
    endtask

    vec_t tab [26];
    vec_t stab [12];

    initial begin
        tab = '{
            '{1'b1, 1'b0, 9'h000,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 9'h1C3,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1C3,   8'd1, 1'b0, 1'b0, 1'b1, 1'b1,  8'd40, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1D2,   8'd2, 1'b1, 1'b1, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1D2,   8'd3, 1'b0, 1'b0, 1'b1, 1'b1,  8'd27, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1E2,   8'd4, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1F5, 8'd255, 1'b0, 1'b0, 1'b1, 1'b1,  8'd66, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1FF,  8'd66, 1'b0, 1'b0, 1'b1, 1'b1,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1FF,  8'd67, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1F1,  8'd68, 1'b0, 1'b0, 1'b1, 1'b1,  8'd14, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h1C0,  8'd14, 1'b1, 1'b1, 1'b1, 1'b1,   8'd1, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h1FE,  8'd81, 1'b0, 1'b0, 1'b1, 1'b1,  8'd81, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h1C3,  8'd81, 1'b0, 1'b0, 1'b1, 1'b1,  8'd81, 1'b1, 1'b1},
            '{1'b0, 1'b0, 9'h000,  8'd81, 1'b0, 1'b0, 1'b1, 1'b1,  8'd81, 1'b1, 1'b1},
            '{1'b0, 1'b1, 9'h000,  8'd81, 1'b0, 1'b0, 1'b1, 1'b1,  8'd81, 1'b1, 1'b1},
            '{1'b0, 1'b0, 9'h1D2,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1FF,   8'd1, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h000,   8'd2, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 9'h1C3,   8'd5, 1'b0, 1'b0, 1'b1, 1'b1,  8'd40, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h1C3,   8'd6, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 9'h1E2,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1E2,   8'd1, 1'b0, 1'b0, 1'b1, 1'b1,  8'd27, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1FD,  8'd10, 1'b0, 1'b0, 1'b1, 1'b1, 8'd170, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1F4,  8'd20, 1'b0, 1'b0, 1'b1, 1'b1,  8'd53, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1FF,  8'd53, 1'b0, 1'b0, 1'b1, 1'b1,  8'd21, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h000,  8'd22, 1'b0, 1'b0, 1'b0, 1'b0,   8'd0, 1'b0, 1'b0}
        };
        stab = '{
            '{1'b0, 1'b1, 9'h000,   8'd0, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1F1,  8'd10, 1'b0, 1'b0, 1'b1, 1'b1,  8'd14, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1F2,  8'd20, 1'b0, 1'b0, 1'b1, 1'b1,  8'd27, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1F3,  8'd30, 1'b0, 1'b0, 1'b1, 1'b1,  8'd40, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1F4,  8'd40, 1'b0, 1'b0, 1'b1, 1'b1,  8'd53, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1F5,  8'd50, 1'b0, 1'b0, 1'b1, 1'b1,  8'd66, 1'b0, 1'b0},
            '{1'b0, 1'b0, 9'h1FF,  8'd66, 1'b0, 1'b0, 1'b1, 1'b1,  8'd41, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h1FF,  8'd41, 1'b0, 1'b0, 1'b1, 1'b1,  8'd31, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h1FF,  8'd31, 1'b0, 1'b0, 1'b1, 1'b1,  8'd21, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h1FF,  8'd21, 1'b0, 1'b0, 1'b1, 1'b1,  8'd11, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h1FF,  8'd11, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 9'h000,  8'd12, 1'b0, 1'b0, 1'b1, 1'b0,   8'd0, 1'b0, 1'b1}
        };

        Reset = 1'b1;
        @(posedge Clk);
        #1;
        armed = 1'b1;

        for (int i = 0; i < 26; i++) apply(tab[i], "v", i);
`ifdef LINK_STACK_EN
        for (int i = 0; i < 12; i++) apply(stab[i], "s", i);
`endif

        @(posedge Clk);
        #1;
        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
